scarv_cop_dispatch: RTL and testbench

Single-issue dispatch stage that sits directly upstream of the packed ALU in the SCARV coprocessor. It accepts one decoded instruction at a time and reads its source operands from the CPR file. It holds the operands stable on the PALU inputs until `palu_idone`, commits the byte-enabled result to the CPR file, and returns a status response to the host CPU. A watchdog bounds how long any PALU operation may stall.

---
 rtl/scarv_cop_dispatch_pkg.sv | 26 ++
 rtl/scarv_cop_dispatch.sv | 174 +++++++++++++++++
 tb/tb_scarv_cop_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_dispatch_pkg.sv
// rtl/scarv_cop_dispatch_pkg.sv - shared class bits, FSM states and response status codes
package scarv_cop_dispatch_pkg;

    localparam int ICLASS_PACKED_ARITH = 0;
    localparam int ICLASS_MOVE         = 4;
    localparam int ICLASS_BITWISE      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } disp_state_t;

    typedef enum logic [2:0] {
        STATUS_OK      = 3'd0,
        STATUS_ILLEGAL = 3'd1,
        STATUS_TIMEOUT = 3'd2
    } cop_status_t;

    // Only the classes the packed ALU can execute are dispatched.
    function automatic logic class_supported(input logic [8:0] cls);
        return cls[ICLASS_PACKED_ARITH] | cls[ICLASS_MOVE] | cls[ICLASS_BITWISE];
    endfunction

endpackage

// File: rtl/scarv_cop_dispatch.sv
// rtl/scarv_cop_dispatch.sv - single-issue dispatch of decoded instructions to the packed ALU
module scarv_cop_dispatch
    import scarv_cop_dispatch_pkg::*;
#(
    parameter int WDOG_CYCLES = 64
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [8:0]  id_class,
    input  logic [14:0] id_subclass,
    input  logic [2:0]  id_pw,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_crs1,
    input  logic [3:0]  id_crs2,
    input  logic [3:0]  id_crs3,
    input  logic [3:0]  id_crd,
    input  logic        id_exception,
    input  logic [31:0] id_gpr_rs1,
    output logic [3:0]  cprs_rs1_addr,
    output logic [3:0]  cprs_rs2_addr,
    output logic [3:0]  cprs_rs3_addr,
    input  logic [31:0] cprs_rs1_rdata,
    input  logic [31:0] cprs_rs2_rdata,
    input  logic [31:0] cprs_rs3_rdata,
    output logic        palu_ivalid,
    input  logic        palu_idone,
    output logic [31:0] palu_rs1,
    output logic [31:0] palu_rs2,
    output logic [31:0] palu_rs3,
    output logic [31:0] gpr_rs1,
    output logic [31:0] palu_imm,
    output logic [2:0]  palu_pw,
    output logic [8:0]  palu_class,
    output logic [14:0] palu_subclass,
    input  logic [3:0]  palu_cpr_rd_ben,
    input  logic [31:0] palu_cpr_rd_wdata,
    output logic [3:0]  cprs_rd_ben,
    output logic [3:0]  cprs_rd_addr,
    output logic [31:0] cprs_rd_wdata,
    output logic        cop_rsp_valid,
    input  logic        cop_rsp_ready,
    output logic [2:0]  cop_rsp_status
);

    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    disp_state_t state, state_nxt;
    cop_status_t status, status_nxt;

    logic [3:0]  crs1_q, crs2_q, crs3_q, crd_q;
    logic [31:0] op1_q, op2_q, op3_q, gpr_q, imm_q;
    logic [2:0]  pw_q;
    logic [8:0]  class_q;
    logic [14:0] subclass_q;
    logic [7:0]  wdog_cnt;
    logic        exec_done;

    // idone on the expiry cycle still wins over the timeout.
    assign exec_done = (state == ST_EXEC) && palu_idone;

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        case (state)
            ST_IDLE: begin
                if (id_valid) begin
                    if (id_exception || !class_supported(id_class)) begin
                        state_nxt  = ST_RESP;
                        status_nxt = STATUS_ILLEGAL;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (palu_idone) begin
                    state_nxt  = ST_RESP;
                    status_nxt = STATUS_OK;
                end else if (wdog_cnt == WDOG_LAST) begin
                    state_nxt  = ST_RESP;
                    status_nxt = STATUS_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (cop_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            status     <= STATUS_OK;
            crs1_q     <= '0;
            crs2_q     <= '0;
            crs3_q     <= '0;
            crd_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            op3_q      <= '0;
            gpr_q      <= '0;
            imm_q      <= '0;
            pw_q       <= '0;
            class_q    <= '0;
            subclass_q <= '0;
            wdog_cnt   <= '0;
        end else begin
            status <= status_nxt;
            case (state)
                ST_IDLE: begin
                    if (id_valid) begin
                        crs1_q     <= id_crs1;
                        crs2_q     <= id_crs2;
                        crs3_q     <= id_crs3;
                        crd_q      <= id_crd;
                        gpr_q      <= id_gpr_rs1;
                        imm_q      <= id_imm;
                        pw_q       <= id_pw;
                        class_q    <= id_class;
                        subclass_q <= id_subclass;
                    end
                end
                ST_READ: begin
                    op1_q    <= cprs_rs1_rdata;
                    op2_q    <= cprs_rs2_rdata;
                    op3_q    <= cprs_rs3_rdata;
                    wdog_cnt <= '0;
                end
                ST_EXEC: begin
                    if (!palu_idone && wdog_cnt != WDOG_LAST) begin
                        wdog_cnt <= wdog_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_ready       = (state == ST_IDLE);
    assign palu_ivalid    = (state == ST_EXEC);
    assign cop_rsp_valid  = (state == ST_RESP);
    assign cop_rsp_status = status;

    assign cprs_rs1_addr  = crs1_q;
    assign cprs_rs2_addr  = crs2_q;
    assign cprs_rs3_addr  = crs3_q;

    assign palu_rs1       = op1_q;
    assign palu_rs2       = op2_q;
    assign palu_rs3       = op3_q;
    assign gpr_rs1        = gpr_q;
    assign palu_imm       = imm_q;
    assign palu_pw        = pw_q;
    assign palu_class     = class_q;
    assign palu_subclass  = subclass_q;

    assign cprs_rd_ben    = exec_done ? palu_cpr_rd_ben   : 4'd0;
    assign cprs_rd_addr   = exec_done ? crd_q             : 4'd0;
    assign cprs_rd_wdata  = exec_done ? palu_cpr_rd_wdata : 32'd0;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// tb/tb_scarv_cop_dispatch.sv - directed self-checking bench for scarv_cop_dispatch
module tb_scarv_cop_dispatch;

    localparam int WDOG = 8;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [8:0]  id_class = '0;
    logic [14:0] id_subclass = '0;
    logic [2:0]  id_pw = '0;
    logic [31:0] id_imm = '0;
    logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crs3 = '0, id_crd = '0;
    logic        id_exception = 1'b0;
    logic [31:0] id_gpr_rs1 = '0;
    logic [3:0]  cprs_rs1_addr, cprs_rs2_addr, cprs_rs3_addr;
    logic [31:0] cprs_rs1_rdata, cprs_rs2_rdata, cprs_rs3_rdata;
    logic        palu_ivalid;
    logic        palu_idone = 1'b0;
    logic [31:0] palu_rs1, palu_rs2, palu_rs3, gpr_rs1, palu_imm;
    logic [2:0]  palu_pw;
    logic [8:0]  palu_class;
    logic [14:0] palu_subclass;
    logic [3:0]  palu_cpr_rd_ben = '0;
    logic [31:0] palu_cpr_rd_wdata = '0;
    logic [3:0]  cprs_rd_ben, cprs_rd_addr;
    logic [31:0] cprs_rd_wdata;
    logic        cop_rsp_valid;
    logic        cop_rsp_ready = 1'b0;
    logic [2:0]  cop_rsp_status;

    logic [31:0] cpr [16];

    assign cprs_rs1_rdata = cpr[cprs_rs1_addr];
    assign cprs_rs2_rdata = cpr[cprs_rs2_addr];
    assign cprs_rs3_rdata = cpr[cprs_rs3_addr];

    scarv_cop_dispatch #(.WDOG_CYCLES(WDOG)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm),
        .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3), .id_crd(id_crd),
        .id_exception(id_exception), .id_gpr_rs1(id_gpr_rs1),
        .cprs_rs1_addr(cprs_rs1_addr), .cprs_rs2_addr(cprs_rs2_addr), .cprs_rs3_addr(cprs_rs3_addr),
        .cprs_rs1_rdata(cprs_rs1_rdata), .cprs_rs2_rdata(cprs_rs2_rdata), .cprs_rs3_rdata(cprs_rs3_rdata),
        .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
        .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3), .gpr_rs1(gpr_rs1),
        .palu_imm(palu_imm), .palu_pw(palu_pw), .palu_class(palu_class), .palu_subclass(palu_subclass),
        .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
        .cprs_rd_ben(cprs_rd_ben), .cprs_rd_addr(cprs_rd_addr), .cprs_rd_wdata(cprs_rd_wdata),
        .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ready(cop_rsp_ready), .cop_rsp_status(cop_rsp_status)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    // Expected per-cycle outputs, written only by the driver.
    logic        chk_en = 1'b0;
    logic        e_id_ready, e_ivalid, e_read, e_rsp_valid, e_wr;
    logic [3:0]  e_ben, e_wr_addr, e_a1, e_a2, e_a3;
    logic [31:0] e_wr_data, e_rs1, e_rs2, e_rs3, e_gpr, e_imm;
    logic [2:0]  e_status, e_pw;
    logic [8:0]  e_class;
    logic [14:0] e_sub;
    int          acc_cyc = 0, base_iv = 0, base_wr = 0, base_rsp = 0;
    int          pin_seq = 0, pin_kind = 0;

    // Observations and counters, written only by the compare process.
    int          nvec = 0, nfail = 0, pin_done = 0;
    int          n_iv_tot = 0, n_wr_tot = 0, n_rsp_tot = 0;
    int          wr_last_cyc = -1, rsp_rise_cyc = -1;
    logic [3:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [2:0]  last_status = '0;
    logic        prev_rsp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge g_clk) begin
        if (chk_en) begin
            chk("id_ready", 32'(id_ready), 32'(e_id_ready));
            chk("palu_ivalid", 32'(palu_ivalid), 32'(e_ivalid));
            chk("cop_rsp_valid", 32'(cop_rsp_valid), 32'(e_rsp_valid));
            chk("cprs_rd_ben", 32'(cprs_rd_ben), 32'(e_wr ? e_ben : 4'd0));
            if (e_wr) begin
                chk("cprs_rd_addr", 32'(cprs_rd_addr), 32'(e_wr_addr));
                chk("cprs_rd_wdata", cprs_rd_wdata, e_wr_data);
            end
            if (e_rsp_valid) chk("cop_rsp_status", 32'(cop_rsp_status), 32'(e_status));
            if (e_read) begin
                chk("cprs_rs1_addr", 32'(cprs_rs1_addr), 32'(e_a1));
                chk("cprs_rs2_addr", 32'(cprs_rs2_addr), 32'(e_a2));
                chk("cprs_rs3_addr", 32'(cprs_rs3_addr), 32'(e_a3));
            end
            if (e_ivalid) begin
                chk("palu_rs1", palu_rs1, e_rs1);
                chk("palu_rs2", palu_rs2, e_rs2);
                chk("palu_rs3", palu_rs3, e_rs3);
                chk("gpr_rs1", gpr_rs1, e_gpr);
                chk("palu_imm", palu_imm, e_imm);
                chk("palu_pw", 32'(palu_pw), 32'(e_pw));
                chk("palu_class", 32'(palu_class), 32'(e_class));
                chk("palu_subclass", 32'(palu_subclass), 32'(e_sub));
            end
            if (palu_ivalid) n_iv_tot++;
            if (cprs_rd_ben != 4'd0) begin
                n_wr_tot++;
                wr_last_cyc  = cyc;
                last_wr_addr = cprs_rd_addr;
                last_wr_data = cprs_rd_wdata;
            end
            if (cop_rsp_valid) begin
                n_rsp_tot++;
                last_status = cop_rsp_status;
                if (!prev_rsp) rsp_rise_cyc = cyc;
            end
            prev_rsp = cop_rsp_valid;
            if (pin_seq != pin_done) begin
                pin_done = pin_seq;
                case (pin_kind)
                    0, 6: begin
                        chk("rst_palu_rs1", palu_rs1, 32'd0);
                        chk("rst_status", 32'(cop_rsp_status), 32'd0);
                        chk("rst_palu_class", 32'(palu_class), 32'd0);
                        chk("rst_rs1_addr", 32'(cprs_rs1_addr), 32'd0);
                        if (pin_kind == 6) begin
                            chk("rst_no_write", 32'(n_wr_tot - base_wr), 32'd0);
                            chk("rst_no_rsp", {31'd0, rsp_rise_cyc > acc_cyc}, 32'd0);
                        end
                    end
                    1: begin
                        chk("add_wr_latency", 32'(wr_last_cyc - acc_cyc), 32'd2);
                        chk("add_rsp_latency", 32'(rsp_rise_cyc - acc_cyc), 32'd3);
                        chk("add_wr_addr", 32'(last_wr_addr), 32'd5);
                        chk("add_wr_data", last_wr_data, 32'h12345678);
                        chk("add_status", 32'(last_status), 32'd0);
                    end
                    2: begin
                        chk("ill_rsp_latency", 32'(rsp_rise_cyc - acc_cyc), 32'd1);
                        chk("ill_status", 32'(last_status), 32'd1);
                        chk("ill_no_ivalid", 32'(n_iv_tot - base_iv), 32'd0);
                        chk("ill_no_write", 32'(n_wr_tot - base_wr), 32'd0);
                    end
                    3: begin
                        chk("mul_ivalid_cycles", 32'(n_iv_tot - base_iv), 32'd4);
                        chk("mul_write_count", 32'(n_wr_tot - base_wr), 32'd1);
                    end
                    4: begin
                        chk("wdog_exec_cycles", 32'(n_iv_tot - base_iv), 32'd8);
                        chk("wdog_no_write", 32'(n_wr_tot - base_wr), 32'd0);
                        chk("wdog_status", 32'(last_status), 32'd2);
                    end
                    5: begin
                        chk("expiry_exec_cycles", 32'(n_iv_tot - base_iv), 32'd8);
                        chk("expiry_write_count", 32'(n_wr_tot - base_wr), 32'd1);
                        chk("expiry_status", 32'(last_status), 32'd0);
                    end
                    7: begin
                        chk("bp_rsp_cycles", 32'(n_rsp_tot - base_rsp), 32'd6);
                        chk("bp_status", 32'(last_status), 32'd0);
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_exp(input logic ir, input logic iv, input logic rd, input logic rv);
        e_id_ready  = ir;
        e_ivalid    = iv;
        e_read      = rd;
        e_rsp_valid = rv;
        e_wr        = 1'b0;
        e_ben       = 4'd0;
    endtask

    task automatic pin(input int kind);
        pin_kind = kind;
        pin_seq  = pin_seq + 1;
    endtask

    // Decoder moves on once the instruction is taken; latched copies must not follow.
    task automatic next_cycle();
        step();
        id_valid     = 1'b0;
        id_class     = ~e_class;
        id_subclass  = ~e_sub;
        id_pw        = ~e_pw;
        id_imm       = ~e_imm;
        id_gpr_rs1   = ~e_gpr;
        id_crs1      = ~e_a1;
        id_crs2      = ~e_a2;
        id_crs3      = ~e_a3;
        id_crd       = ~e_wr_addr;
        id_exception = 1'b0;
    endtask

    task automatic run(input logic [8:0] cls, input logic exc,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] d,
                       input int idone_d, input logic [3:0] ben, input logic [31:0] wd,
                       input int rdy_d, input int rst_at);
        logic       legal;
        logic [2:0] st;
        logic [3:0] crd;
        bit         done;
        legal = !exc && (cls[0] || cls[4] || cls[6]);
        crd   = d;
        step();
        e_class = cls;  e_sub = {11'h5A5, d};  e_pw = 3'(d);
        e_imm = 32'hF00D0000 | {28'd0, d};  e_gpr = 32'h600D0000 ^ {28'd0, s1};
        e_a1 = s1;  e_a2 = s2;  e_a3 = s3;
        e_rs1 = cpr[s1];  e_rs2 = cpr[s2];  e_rs3 = cpr[s3];
        id_valid = 1'b1;  id_exception = exc;
        id_class = cls;  id_subclass = e_sub;  id_pw = e_pw;  id_imm = e_imm;  id_gpr_rs1 = e_gpr;
        id_crs1 = s1;  id_crs2 = s2;  id_crs3 = s3;  id_crd = d;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        acc_cyc = cyc;  base_iv = n_iv_tot;  base_wr = n_wr_tot;  base_rsp = n_rsp_tot;
        st = 3'd1;
        if (legal) begin
            next_cycle();
            set_exp(1'b0, 1'b0, 1'b1, 1'b0);
            st   = 3'd2;
            done = 1'b0;
            for (int k = 0; k < WDOG && !done; k++) begin
                next_cycle();
                set_exp(1'b0, 1'b1, 1'b0, 1'b0);
                palu_cpr_rd_ben   = 4'hF;
                palu_cpr_rd_wdata = 32'hDEADBEEF;
                palu_idone        = 1'b0;
                if (k == rst_at) begin
                    g_resetn = 1'b0;
                    step();
                    g_resetn = 1'b1;
                    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
                    pin(6);
                    return;
                end
                if (k == idone_d) begin
                    palu_idone = 1'b1;  palu_cpr_rd_ben = ben;  palu_cpr_rd_wdata = wd;
                    e_wr = 1'b1;  e_ben = ben;  e_wr_addr = crd;  e_wr_data = wd;
                    st = 3'd0;
                    done = 1'b1;
                end
            end
        end
        for (int j = 0; j <= rdy_d; j++) begin
            next_cycle();
            palu_idone        = 1'b1;
            palu_cpr_rd_ben   = 4'hF;
            palu_cpr_rd_wdata = 32'h0BADF00D;
            set_exp(1'b0, 1'b0, 1'b0, 1'b1);
            e_status      = st;
            cop_rsp_ready = (j == rdy_d);
        end
        step();
        cop_rsp_ready = 1'b0;
        palu_idone    = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) cpr[i] = 32'hC0DE0000 + 32'(i) * 32'h00010111;
        e_wr_addr = '0;  e_wr_data = '0;  e_status = '0;
        e_a1 = '0;  e_a2 = '0;  e_a3 = '0;  e_rs1 = '0;  e_rs2 = '0;  e_rs3 = '0;
        e_gpr = '0;  e_imm = '0;  e_pw = '0;  e_class = '0;  e_sub = '0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        g_resetn = 1'b1;
        step();
        chk_en = 1'b1;
        pin(0);
        // class, exc, crs1..3, crd, idone delay, ben, wdata, ready delay, reset point
        run(9'h001, 1'b0, 4'd1, 4'd2, 4'd3, 4'd5,   0, 4'hF, 32'h12345678, 0, -1);  pin(1);
        run(9'h001, 1'b0, 4'd7, 4'd8, 4'd0, 4'd9,   3, 4'h3, 32'hCAFEF00D, 1, -1);  pin(3);
        run(9'h001, 1'b1, 4'd4, 4'd5, 4'd6, 4'd2,   0, 4'hF, 32'h0,        0, -1);  pin(2);
        run(9'h002, 1'b0, 4'd4, 4'd5, 4'd6, 4'd3,   0, 4'hF, 32'h0,        0, -1);  pin(2);
        run(9'h010, 1'b0, 4'd10, 4'd11, 4'd12, 4'd1, 100, 4'hF, 32'h0,     0, -1);  pin(4);
        run(9'h040, 1'b0, 4'd13, 4'd14, 4'd15, 4'd6, 7, 4'hC, 32'hA5A5A5A5, 0, -1); pin(5);
        run(9'h001, 1'b0, 4'd2, 4'd4, 4'd8, 4'd11,  1, 4'h1, 32'h00000077, 5, -1);  pin(7);
        run(9'h010, 1'b0, 4'd3, 4'd3, 4'd3, 4'd4,   0, 4'h0, 32'h55555555, 0, -1);
        run(9'h001, 1'b0, 4'd6, 4'd9, 4'd12, 4'd14, 5, 4'hF, 32'h99999999, 0, 2);
        run(9'h001, 1'b0, 4'd1, 4'd2, 4'd3, 4'd5,   0, 4'hF, 32'h12345678, 0, -1);  pin(1);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
